// File: rtl/mskaes_ctrl_pkg.sv
// Shared definitions for the masked AES round sequencers: state encoding and widths.
// No logic of its own; no latency or flow control.
package mskaes_ctrl_pkg;

    localparam int NROUNDS = 10;
    localparam int ROUND_W = 4;
    localparam int CNT_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FEED,
        ST_WAIT,
        ST_COMMIT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/mskaes_ctrl_delay_cnt.sv
// Loadable down-counter with a terminal flag; load wins over decrement, saturates at 0.
// Flag is registered-state decoded (same cycle as the count); no flow control.
module mskaes_ctrl_delay_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A count of 1 marks the last waiting cycle; 0 is treated the same so it cannot stick.
    assign done = (cnt_q <= CNT_W'(1));
    assign cnt  = cnt_q;

endmodule

// File: rtl/mskaes_round_ctrl.sv
// Masked AES-128 round sequencer: LOAD, then 10 x (FEED, SBOX_LAT-1 x WAIT, COMMIT), then DONE.
// Result after 10*(SBOX_LAT+1)+2 cycles; one request in flight, DONE holds out_valid until out_ready.
module mskaes_round_ctrl
    import mskaes_ctrl_pkg::*;
#(
    parameter int d        = 2,
    parameter int SBOX_LAT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               state_load,
    output logic               sbox_feed,
    output logic               state_commit,
    output logic               mc_bypass,
    output logic [ROUND_W-1:0] round,
    output logic               rcon_rst,
    output logic               rcon_update,
    output logic               rcon_mask
);

    if (d < 1 || SBOX_LAT < 1 || SBOX_LAT > 15) begin : g_param_check
        $error("mskaes_round_ctrl: d must be >= 1 and SBOX_LAT within 1..15");
    end

    state_e             state_q, state_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic               cnt_load, cnt_dec, cnt_done;
    logic [CNT_W-1:0]   cnt_val;
    logic               rcon_rst_st;

    mskaes_ctrl_delay_cnt #(.CNT_W(CNT_W)) u_delay_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (CNT_W'(SBOX_LAT - 1)),
        .dec      (cnt_dec),
        .cnt      (cnt_val),
        .done     (cnt_done)
    );

    always_comb begin
        state_d      = state_q;
        round_d      = round_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        state_load   = 1'b0;
        sbox_feed    = 1'b0;
        state_commit = 1'b0;
        mc_bypass    = 1'b0;
        rcon_rst_st  = 1'b0;
        rcon_update  = 1'b0;
        rcon_mask    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready    = 1'b1;
                rcon_rst_st = 1'b1;
                if (in_valid) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                busy        = 1'b1;
                state_load  = 1'b1;
                rcon_rst_st = 1'b1;
                round_d     = ROUND_W'(1);
                state_d     = ST_FEED;
            end
            ST_FEED: begin
                busy      = 1'b1;
                sbox_feed = 1'b1;
                cnt_load  = 1'b1;
                state_d   = (SBOX_LAT > 1) ? ST_WAIT : ST_COMMIT;
            end
            ST_WAIT: begin
                busy    = 1'b1;
                cnt_dec = 1'b1;
                if (cnt_done) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                busy         = 1'b1;
                state_commit = 1'b1;
                rcon_update  = 1'b1;
                rcon_mask    = 1'b1;
                mc_bypass    = (round_q == ROUND_W'(NROUNDS));
                if (round_q == ROUND_W'(NROUNDS)) begin
                    state_d = ST_DONE;
                end else begin
                    round_d = round_q + ROUND_W'(1);
                    state_d = ST_FEED;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    round_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                round_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    // The rcon generator must sit at 0x01 while this block is held in reset.
    assign rcon_rst = rcon_rst_st | ~rst_n;
    assign round    = round_q;

endmodule
